ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter, the send-side counterpart of ps2_keyboard.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) over the shared
//  open-drain ps2_clk/ps2_data lines. Sits beside ps2_keyboard in top; the line
//  drivers are resolved by the top-level/board tristate logic.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles the host holds ps2_clk low (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max cycles from clock release to ACK (15 ms @ 50 MHz)
// PORTS
//  clk               in   1  system clock
//  resetn            in   1  synchronous, active-low reset
//  tx_valid          in   1  request to send tx_data
//  tx_data           in   8  command byte
//  tx_ready          out  1  high in IDLE only; byte accepted when tx_valid&tx_ready
//  ps2_clk           in   1  sampled PS/2 clock line (asynchronous)
//  ps2_data          in   1  sampled PS/2 data line (asynchronous)
//  ps2_clk_drv_low   out  1  1 = pull ps2_clk low, 0 = release
//  ps2_data_drv_low  out  1  1 = pull ps2_data low, 0 = release
//  tx_done           out  1  1-cycle pulse: frame finished, device ACKed
//  tx_err            out  1  1-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state IDLE, both drv_low=0, tx_done=tx_err=0,
//    tx_ready=1 from the first cycle after reset; an active frame is abandoned,
//    lines released immediately.
//  - ps2_clk/ps2_data pass through 2-FF synchronisers; falling edge = prev 1,
//    now 0 on synchronised clock. Edge decisions act 3 cycles after the pin.
//  - Accept: tx_valid&tx_ready latches {odd parity, tx_data}; next state INHIBIT.
//  - INHIBIT: clk_drv_low=1 for INHIBIT_CYCLES; data_drv_low=1 in the last cycle.
//  - REQ: clk_drv_low=0, data_drv_low=1 (start bit); timeout counter cleared,
//    counts every cycle in REQ/SHIFT/ACK/RELEASE.
//  - SHIFT: falling edges 1..8 drive d0..d7 (LSB first; drv_low = ~bit), edge 9
//    drives parity = ~^tx_data, edge 10 releases data (stop bit).
//  - ACK: on edge 11 sample ps2_data; 0 = ACK, 1 = NACK.
//  - RELEASE: wait for synced clk=1 and data=1, then pulse tx_done (ACK) or
//    tx_err (NACK), return to IDLE.
//  - Timeout: counter reaching TIMEOUT_CYCLES-1 in any of REQ..RELEASE ->
//    release both lines, pulse tx_err, IDLE.
//  - tx_valid outside IDLE is ignored (no queueing); tx_data sampled only on accept.
//  - Falling edges seen in IDLE/INHIBIT (device transmitting) are ignored; host
//    inhibit has priority per PS/2 protocol.
//  - Counters: inhibit counter $clog2(INHIBIT_CYCLES), timeout counter
//    $clog2(TIMEOUT_CYCLES), edge counter 4 bits; no wrap, cleared per frame.
//  - tx_done and tx_err never assert in the same cycle.
// CONFIGURATION
//  PS2_HOST_TX_RETRY_EN defined: on NACK or timeout the latched byte is resent
//    once (re-enter INHIBIT, tx_ready stays 0); tx_err pulses only if the retry
//    also fails; tx_done on success of either attempt.
//  Not defined: first NACK/timeout pulses tx_err and returns to IDLE.
// TESTING
//  Bench: device model clocking at 12.5 kHz, INHIBIT_CYCLES=50, TIMEOUT_CYCLES=20000.
//  1 Send 0xED, device ACKs -> clk low 50 cycles; device samples bits
//    1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; tx_done 1 pulse; tx_ready=1.
//  2 Send 0x00 -> parity bit sampled 1; send 0x01 -> parity 0; both tx_done.
//  3 Device answers with data=1 on edge 11 -> tx_err pulse, no tx_done
//    (RETRY_EN: second frame identical to first, then tx_err).
//  4 Device never clocks -> tx_err exactly TIMEOUT_CYCLES after REQ entry,
//    both drv_low=0.
//  5 resetn=0 after edge 5 -> next cycle both drv_low=0, tx_ready=1, no pulses;
//    new 0xFF send then completes with tx_done.
//  6 tx_valid held with new data mid-frame -> ignored; only first byte seen by device.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the open-drain ps2_clk/ps2_data lines through *_drv_low enables.
// The board-level tristate logic resolves these enables onto the pins.
// Optional feature: define PS2_HOST_TX_RETRY_EN to resend a byte once after a
// NACK or a timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drv_low,
  output logic       ps2_data_drv_low,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PEN  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  // With a one-cycle inhibit, the start bit must already be asserted on entry.
  localparam logic             INH_ONE  = (INHIBIT_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic              clk_s1, clk_s2, clk_s3, data_s1, data_s2;
  logic              clk_fall;
  logic [8:0]        frame_q, frame_nxt;
  logic [INH_W-1:0]  inh_cnt, inh_cnt_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [3:0]        edge_cnt, edge_cnt_nxt;
  logic              acked, acked_nxt;
  logic              clk_drv_nxt, data_drv_nxt, done_nxt, err_nxt;
  logic              fail, timeout;
`ifdef PS2_HOST_TX_RETRY_EN
  logic              retry_used, retry_used_nxt;
`endif

  assign tx_ready = (state == S_IDLE);
  // The edge detector looks at the second synchroniser stage and its delayed copy.
  assign clk_fall = clk_s3 & ~clk_s2;

  // Bring the asynchronous PS/2 lines into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Control state, counters and registered line drivers / status pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= S_IDLE;
      inh_cnt          <= '0;
      to_cnt           <= '0;
      edge_cnt         <= '0;
      acked            <= 1'b0;
      ps2_clk_drv_low  <= 1'b0;
      ps2_data_drv_low <= 1'b0;
      tx_done          <= 1'b0;
      tx_err           <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_used       <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      inh_cnt          <= inh_cnt_nxt;
      to_cnt           <= to_cnt_nxt;
      edge_cnt         <= edge_cnt_nxt;
      acked            <= acked_nxt;
      ps2_clk_drv_low  <= clk_drv_nxt;
      ps2_data_drv_low <= data_drv_nxt;
      tx_done          <= done_nxt;
      tx_err           <= err_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_used       <= retry_used_nxt;
`endif
    end
  end

  // Latched frame {odd parity, byte}; kept intact so a retry can resend it.
  always_ff @(posedge clk) begin
    frame_q <= frame_nxt;
  end

  // Next-state, counter and line-driver decisions for the transmit sequence.
  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame_q;
    inh_cnt_nxt  = inh_cnt;
    to_cnt_nxt   = to_cnt;
    edge_cnt_nxt = edge_cnt;
    acked_nxt    = acked;
    clk_drv_nxt  = ps2_clk_drv_low;
    data_drv_nxt = ps2_data_drv_low;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    fail         = 1'b0;
    timeout      = (to_cnt == TO_LAST);
`ifdef PS2_HOST_TX_RETRY_EN
    retry_used_nxt = retry_used;
`endif

    case (state)
      S_IDLE: begin
        clk_drv_nxt  = 1'b0;
        data_drv_nxt = 1'b0;
        if (tx_valid) begin
          frame_nxt    = {~^tx_data, tx_data};
          state_nxt    = S_INHIBIT;
          inh_cnt_nxt  = '0;
          clk_drv_nxt  = 1'b1;
          data_drv_nxt = INH_ONE;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_used_nxt = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        // Device edges are ignored here: host inhibit wins.
        if (inh_cnt == INH_LAST) begin
          state_nxt    = S_REQ;
          to_cnt_nxt   = '0;
          edge_cnt_nxt = '0;
          clk_drv_nxt  = 1'b0;
          data_drv_nxt = 1'b1;
        end else begin
          inh_cnt_nxt = inh_cnt + 1'b1;
          if (inh_cnt == INH_PEN) data_drv_nxt = 1'b1;
        end
      end
      S_REQ: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (clk_fall) begin
            data_drv_nxt = ~frame_q[0];
            edge_cnt_nxt = 4'd1;
            state_nxt    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (clk_fall) begin
            edge_cnt_nxt = edge_cnt + 1'b1;
            if (edge_cnt == 4'd9) begin
              // Tenth edge: release data so the device sees the stop bit.
              data_drv_nxt = 1'b0;
              state_nxt    = S_ACK;
            end else begin
              data_drv_nxt = ~frame_q[edge_cnt];
            end
          end
        end
      end
      S_ACK: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (clk_fall) begin
            edge_cnt_nxt = edge_cnt + 1'b1;
            acked_nxt    = ~data_s2;
            state_nxt    = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (timeout) begin
          fail = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (clk_s2 && data_s2) begin
            if (acked) begin
              done_nxt     = 1'b1;
              state_nxt    = S_IDLE;
              clk_drv_nxt  = 1'b0;
              data_drv_nxt = 1'b0;
            end else begin
              fail = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        clk_drv_nxt  = 1'b0;
        data_drv_nxt = 1'b0;
      end
    endcase

    // NACK or timeout: give up (or resend once when retry is enabled).
    if (fail) begin
      done_nxt = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retry_used) begin
        retry_used_nxt = 1'b1;
        state_nxt      = S_INHIBIT;
        inh_cnt_nxt    = '0;
        edge_cnt_nxt   = '0;
        clk_drv_nxt    = 1'b1;
        data_drv_nxt   = INH_ONE;
      end else begin
        state_nxt    = S_IDLE;
        err_nxt      = 1'b1;
        clk_drv_nxt  = 1'b0;
        data_drv_nxt = 1'b0;
      end
`else
      state_nxt    = S_IDLE;
      err_nxt      = 1'b1;
      clk_drv_nxt  = 1'b0;
      data_drv_nxt = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a 12.5 kHz PS/2 device model.
// System clock is 1 MHz, so one device clock half-period is 40 system cycles.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TMO  = 20000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_drv_low, ps2_data_drv_low, tx_done, tx_err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cyc = 0, inh_data_cyc = 0;

  logic [7:0] rx_byte, rx_byte2;
  logic       rx_par, rx_stop, rx_par2, rx_stop2;
  bit         rx_ok, rx_ok2, got;

  assign ps2_clk_line  = ~(ps2_clk_drv_low  | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_drv_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line),
    .ps2_clk_drv_low(ps2_clk_drv_low), .ps2_data_drv_low(ps2_data_drv_low),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #500 clk = ~clk;

  // Activity counters sampled on the falling edge of the system clock.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_drv_low) inh_cyc <= inh_cyc + 1;
    if (ps2_clk_drv_low && ps2_data_drv_low) inh_data_cyc <= inh_data_cyc + 1;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock n_edges bits in, optionally ACK.
  task automatic device_rx(input bit ack, input int n_edges, output logic [7:0] b,
                           output logic par, output logic stop, output bit ok);
    int n;
    logic [9:0] bits;
    ok = 1'b1;
    bits = '0;
    n = 0;
    while (ps2_clk_line !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) ok = 1'b0;
    n = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) ok = 1'b0;
    if (ok) begin
      repeat (10) @(negedge clk);
      for (int i = 1; i <= n_edges && i <= 10; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        bits[i-1] = ps2_data_line;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      if (n_edges >= 11) begin
        dev_data_low = ack;
        repeat (HALF/2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF/2) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
    b = bits[7:0];
    par = bits[8];
    stop = bits[9];
  endtask

  task automatic wait_result(input int d0, input int e0, output bit ok);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin @(negedge clk); n++; end
    ok = (n < 3000);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ps2_clk_drv_low !== 1'b0) begin miscompares++; $display("FAIL reset_clk_drv: got %b want 0", ps2_clk_drv_low); end
    vectors++; if (ps2_data_drv_low !== 1'b0) begin miscompares++; $display("FAIL reset_data_drv: got %b want 0", ps2_data_drv_low); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    vectors++; if ({tx_done, tx_err} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_err}); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_send_ed();
    int d0, e0, i0, id0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cyc; id0 = inh_data_cyc;
    send(8'hED);
    device_rx(1'b1, 11, rx_byte, rx_par, rx_stop, rx_ok);
    wait_result(d0, e0, got);
    vectors++; if (!(rx_ok && got)) begin miscompares++; $display("FAIL ed_progress: got dev=%b res=%b want 1 1", rx_ok, got); end
    vectors++; if (inh_cyc - i0 !== INH) begin miscompares++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh_cyc - i0, INH); end
    vectors++; if (inh_data_cyc - id0 !== 1) begin miscompares++; $display("FAIL ed_start_overlap: got %0d want 1", inh_data_cyc - id0); end
    vectors++; if (rx_byte !== 8'hED) begin miscompares++; $display("FAIL ed_byte: got %h want ed", rx_byte); end
    vectors++; if ({rx_par, rx_stop} !== 2'b11) begin miscompares++; $display("FAIL ed_par_stop: got %b want 11", {rx_par, rx_stop}); end
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL ed_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL ed_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2];
    logic       pars [2];
    int d0, e0;
    vals[0] = 8'h00; pars[0] = 1'b1;
    vals[1] = 8'h01; pars[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt; e0 = err_cnt;
      send(vals[k]);
      device_rx(1'b1, 11, rx_byte, rx_par, rx_stop, rx_ok);
      wait_result(d0, e0, got);
      vectors++; if (rx_byte !== vals[k] || rx_stop !== 1'b1) begin miscompares++; $display("FAIL par_byte%0d: got %h stop %b want %h stop 1", k, rx_byte, rx_stop, vals[k]); end
      vectors++; if (rx_par !== pars[k]) begin miscompares++; $display("FAIL par_bit%0d: got %b want %b", k, rx_par, pars[k]); end
      vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL par_done%0d: got done=%0d err=%0d want 1 0", k, done_cnt - d0, err_cnt - e0); end
    end
  endtask

  task automatic test_nack();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A);
    device_rx(1'b0, 11, rx_byte, rx_par, rx_stop, rx_ok);
`ifdef PS2_HOST_TX_RETRY_EN
    device_rx(1'b0, 11, rx_byte2, rx_par2, rx_stop2, rx_ok2);
    vectors++; if ({rx_byte2, rx_par2, rx_stop2} !== {rx_byte, rx_par, rx_stop} || !rx_ok2) begin miscompares++; $display("FAIL nack_retry_frame: got %h/%b want %h/%b", rx_byte2, rx_par2, rx_byte, rx_par); end
`endif
    wait_result(d0, e0, got);
    vectors++; if (rx_byte !== 8'h5A || rx_par !== 1'b1) begin miscompares++; $display("FAIL nack_byte: got %h par %b want 5a par 1", rx_byte, rx_par); end
    vectors++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin miscompares++; $display("FAIL nack_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL nack_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int n, d0, e0, want;
`ifdef PS2_HOST_TX_RETRY_EN
    want = TMO + INH + TMO;
`else
    want = TMO;
`endif
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12);
    n = 0;
    while (ps2_clk_drv_low !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (tx_err !== 1'b1 && n < 3 * TMO) begin @(negedge clk); n++; end
    vectors++; if (n !== want) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", n, want); end
    vectors++; if ({ps2_clk_drv_low, ps2_data_drv_low} !== 2'b00) begin miscompares++; $display("FAIL timeout_release: got %b want 00", {ps2_clk_drv_low, ps2_data_drv_low}); end
    repeat (5) @(negedge clk);
    vectors++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin miscompares++; $display("FAIL timeout_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send(8'h77);
    device_rx(1'b1, 5, rx_byte, rx_par, rx_stop, rx_ok);
    vectors++; if (tx_ready !== 1'b0 || ps2_data_drv_low !== ~rx_byte[4]) begin miscompares++; $display("FAIL mid_frame_state: got ready=%b drv=%b want 0 %b", tx_ready, ps2_data_drv_low, ~rx_byte[4]); end
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    vectors++; if ({ps2_clk_drv_low, ps2_data_drv_low} !== 2'b00) begin miscompares++; $display("FAIL rst_mid_release: got %b want 00", {ps2_clk_drv_low, ps2_data_drv_low}); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", tx_ready); end
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (done_cnt !== d0 || err_cnt !== e0) begin miscompares++; $display("FAIL rst_mid_pulses: got done=%0d err=%0d want %0d %0d", done_cnt, err_cnt, d0, e0); end
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    device_rx(1'b1, 11, rx_byte, rx_par, rx_stop, rx_ok);
    wait_result(d0, e0, got);
    vectors++; if (rx_byte !== 8'hFF || rx_par !== 1'b1) begin miscompares++; $display("FAIL rst_then_ff: got %h par %b want ff par 1", rx_byte, rx_par); end
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rst_then_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_ignore_mid();
    int d0, e0, i0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cyc;
    send(8'hA5);
    fork
      device_rx(1'b1, 11, rx_byte, rx_par, rx_stop, rx_ok);
      begin
        repeat (200) @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %b want 0", tx_ready); end
        repeat (400) @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    join
    wait_result(d0, e0, got);
    repeat (20) @(negedge clk);
    vectors++; if (rx_byte !== 8'hA5 || rx_par !== 1'b1) begin miscompares++; $display("FAIL busy_byte: got %h par %b want a5 par 1", rx_byte, rx_par); end
    vectors++; if (done_cnt - d0 !== 1 || inh_cyc - i0 !== INH) begin miscompares++; $display("FAIL busy_single_frame: got done=%0d inhibit=%0d want 1 %0d", done_cnt - d0, inh_cyc - i0, INH); end
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_ignore_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
